// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared types and constant tables for the Keccak-f[1600] permutation core.
//   lane_t   : one 64-bit lane, bit z of the lane is bit z of the word (z=0 LSB)
//   state_t  : 5x5 lanes, indexed state[x][y]
//   RC       : iota round constants RC[0..23]
//   RHO      : rho rotation offsets, indexed RHO[x][y]
//   rotl     : 64-bit rotate-left helper
// -----------------------------------------------------------------------------
package keccak_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [0:4][0:4] state_t;

  localparam lane_t RC [0:23] = '{
    64'h0000_0000_0000_0001, 64'h0000_0000_0000_8082,
    64'h8000_0000_0000_808A, 64'h8000_0000_8000_8000,
    64'h0000_0000_0000_808B, 64'h0000_0000_8000_0001,
    64'h8000_0000_8000_8081, 64'h8000_0000_0000_8009,
    64'h0000_0000_0000_008A, 64'h0000_0000_0000_0088,
    64'h0000_0000_8000_8009, 64'h0000_0000_8000_000A,
    64'h0000_0000_8000_808B, 64'h8000_0000_0000_008B,
    64'h8000_0000_0000_8089, 64'h8000_0000_0000_8003,
    64'h8000_0000_0000_8002, 64'h8000_0000_0000_0080,
    64'h0000_0000_0000_800A, 64'h8000_0000_8000_000A,
    64'h8000_0000_8000_8081, 64'h8000_0000_0000_8080,
    64'h0000_0000_8000_0001, 64'h8000_0000_8000_8008
  };

  // Stored column-major: each inner list is one x, running y = 0..4.
  localparam int unsigned RHO [0:4][0:4] = '{
    '{32'd0,  32'd36, 32'd3,  32'd41, 32'd18},
    '{32'd1,  32'd44, 32'd10, 32'd45, 32'd2 },
    '{32'd62, 32'd6,  32'd43, 32'd15, 32'd61},
    '{32'd28, 32'd55, 32'd25, 32'd21, 32'd56},
    '{32'd27, 32'd20, 32'd39, 32'd8,  32'd14}
  };

  // Rotate left by n (0..63); the upper half of the doubled word is the result,
  // which also covers n = 0 without a special case.
  function automatic lane_t rotl(input lane_t x, input int unsigned n);
    logic [127:0] w;
    w = {x, x} << n;
    return w[127:64];
  endfunction

endpackage

// File: rtl/keccak_round.sv
// -----------------------------------------------------------------------------
// keccak_round
// One combinational Keccak-f[1600] round: theta, rho, pi, chi, iota.
//   A_in      : state entering the round
//   rc        : iota round constant for this round
//   A_out     : state after the full round
//   theta_out : state after theta only (observation point)
// -----------------------------------------------------------------------------
module keccak_round
  import keccak_pkg::*;
(
  input  state_t A_in,
  input  lane_t  rc,
  output state_t A_out,
  output state_t theta_out
);

  lane_t  [0:4] w_c;
  lane_t  [0:4] w_d;
  state_t       w_b;
  state_t       w_chi;

  for (genvar gx = 0; gx < 5; gx++) begin : g_col
    // Column parity and the theta correction term for column gx.
    assign w_c[gx] = A_in[gx][0] ^ A_in[gx][1] ^ A_in[gx][2] ^ A_in[gx][3] ^ A_in[gx][4];
    assign w_d[gx] = w_c[(gx + 4) % 5] ^ rotl(w_c[(gx + 1) % 5], 32'd1);
  end

  for (genvar gx = 0; gx < 5; gx++) begin : g_x
    for (genvar gy = 0; gy < 5; gy++) begin : g_y
      assign theta_out[gx][gy] = A_in[gx][gy] ^ w_d[gx];
      // rho rotates in place, pi moves lane (x,y) to (y, 2x+3y).
      assign w_b[gy][(2 * gx + 3 * gy) % 5] = rotl(theta_out[gx][gy], RHO[gx][gy]);
      assign w_chi[gx][gy] = w_b[gx][gy] ^ (~w_b[(gx + 1) % 5][gy] & w_b[(gx + 2) % 5][gy]);
      if (gx == 0 && gy == 0) begin : g_iota
        assign A_out[gx][gy] = w_chi[gx][gy] ^ rc;
      end else begin : g_pass
        assign A_out[gx][gy] = w_chi[gx][gy];
      end
    end
  end

endmodule

// File: rtl/keccak_f_core.sv
// -----------------------------------------------------------------------------
// keccak_f_core
// Iterative Keccak-f[1600] permutation, one round per clock.
//   NR     : rounds per permutation (1..24)
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : load A_in and begin a permutation (ignored while busy)
//   A_in   : input state, lane A_in[x][y]
//   A_out  : state register, valid while done=1 and held until next start
//   busy   : rounds in progress
//   done   : one-cycle pulse when A_out holds a finished result
// -----------------------------------------------------------------------------
module keccak_f_core
  import keccak_pkg::*;
#(
  parameter int NR = 24
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  state_t A_in,
  output state_t A_out,
  output logic   busy,
  output logic   done
);

  localparam logic [4:0] LAST_RND = 5'(NR - 1);

  state_t     r_state;
  logic [4:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  state_t     w_next;
  lane_t      w_rc;

  assign w_rc = RC[r_cnt];

  keccak_round u_round (
    .A_in      (r_state),
    .rc        (w_rc),
    .A_out     (w_next),
    .theta_out ()
  );

  // State register, round counter and busy/done control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_state <= w_next;
        // Final round: the counter is held so RC stays in range.
        if (r_cnt == LAST_RND) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end else if (start) begin
        r_state <= A_in;
        r_cnt   <= 5'd0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign A_out = r_state;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_keccak_f_core.sv
module tb_keccak_f_core;
  import keccak_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  state_t a_in;
  state_t a_out;
  logic   busy;
  logic   done;

  state_t t_in;
  lane_t  t_rc;
  state_t t_out;
  state_t t_theta;

  state_t junk;
  state_t prev;
  state_t snap;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n;
  logic   ok_a;
  logic   ok_b;

  keccak_f_core #(.NR(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A_in  (a_in),
    .A_out (a_out),
    .busy  (busy),
    .done  (done)
  );

  keccak_round u_rnd (
    .A_in      (t_in),
    .rc        (t_rc),
    .A_out     (t_out),
    .theta_out (t_theta)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge (edge 0); returns at the following falling edge.
  task automatic kick(input state_t a);
    a_in  = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after edge 0 until done is seen; pulses start on edges s1+1, s2+1.
  task automatic wait_done(input int s1, input int s2, output int cnt);
    cnt = 0;
    while (cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (done) begin
        start = 1'b0;
        break;
      end
      start = (cnt == s1) || (cnt == s2);
      if (start) a_in = junk;
    end
  endtask

  function automatic lane_t exp_theta(input int x, input int y);
    case (x)
      0:       return (y == 0) ? 64'h1e : 64'h01;
      1:       return (y == 3) ? 64'h8000_0000_0000_001f : 64'h1f;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0;
      default: return 64'h3e;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    t_in  = '0;
    t_rc  = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        junk[x][y] = 64'hA5A5_5A5A_0000_0000 | 64'(x * 5 + y + 1);

    // Reset state, before any clock edge
    #2;
    check("rst_aout00", a_out[0][0], 64'h0);
    check("rst_aout44", a_out[4][4], 64'h0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    // Round unit: theta
    t_in[0][0] = 64'h1f;
    t_in[1][3] = 64'h8000_0000_0000_0000;
    #1;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        check($sformatf("theta[%0d][%0d]", x, y), t_theta[x][y], exp_theta(x, y));

    // Round unit: zero state only picks up iota
    t_in = '0;
    t_rc = 64'h8000_0000_8000_8008;
    #1;
    check("rnd0_00", t_out[0][0], 64'h8000_0000_8000_8008);
    check("rnd0_10", t_out[1][0], 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-state permutation
    kick('0);
    check("zp_busy", {63'd0, busy}, 64'd1);
    wait_done(-1, -1, n);
    check("zp_lat", 64'(n), 64'd24);
    check("zp_00", a_out[0][0], 64'hF125_8F79_40E1_DDE7);
    check("zp_10", a_out[1][0], 64'h84D5_CCF9_33C0_478A);
    check("zp_busy_done", {63'd0, busy}, 64'd0);
    prev = a_out;
    @(negedge clk);
    check("zp_pulse", {63'd0, done}, 64'd0);
    check("zp_hold", {63'd0, a_out === prev}, 64'd1);

    // start pulses during rounds are ignored
    kick('0);
    wait_done(5, 23, n);
    check("ign_lat", 64'(n), 64'd24);
    check("ign_00", a_out[0][0], 64'hF125_8F79_40E1_DDE7);
    check("ign_10", a_out[1][0], 64'h84D5_CCF9_33C0_478A);
    ok_a = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok_a = ok_a && !done && !busy;
    end
    check("ign_no_extra", {63'd0, ok_a}, 64'd1);

    // Reset in the middle of a permutation
    kick('0);
    repeat (10) @(negedge clk);
    check("ab_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("ab_00", a_out[0][0], 64'h0);
    check("ab_10", a_out[1][0], 64'h0);
    check("ab_busy", {63'd0, busy}, 64'd0);
    check("ab_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok_a = 1'b1;
    repeat (30) begin
      @(negedge clk);
      ok_a = ok_a && !done;
    end
    check("ab_no_done", {63'd0, ok_a}, 64'd1);
    kick('0);
    wait_done(-1, -1, n);
    check("ab_lat", 64'(n), 64'd24);
    check("ab_re00", a_out[0][0], 64'hF125_8F79_40E1_DDE7);

    // Back-to-back: restart in the done cycle with the previous result
    prev = a_out;
    kick(prev);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_done", {63'd0, done}, 64'd0);
    wait_done(-1, -1, n);
    check("b2b_lat", 64'(n), 64'd24);
    check("b2b_00", a_out[0][0], 64'h2D5C_954D_F96E_CB3C);
    check("b2b_10", a_out[1][0], 64'h6A33_2CD0_7057_B56D);

    // Idle stability
    @(negedge clk);
    snap = a_out;
    ok_a = 1'b1;
    ok_b = 1'b1;
    repeat (100) begin
      @(negedge clk);
      ok_a = ok_a && (a_out === snap);
      ok_b = ok_b && !busy && !done;
    end
    check("idle_aout", {63'd0, ok_a}, 64'd1);
    check("idle_ctrl", {63'd0, ok_b}, 64'd1);
    check("idle_00", a_out[0][0], 64'h2D5C_954D_F96E_CB3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_f_core.md
KECCAK_F_CORE -- requirements
Module: keccak_f

Interface
REQ-001 Parameter NR, default 24: number of rounds executed per permutation (legal range 1..24).
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 start  input  1  request to permute A_in; sampled on the rising edge.
REQ-005 A_in  input  [0:4][0:4] x 64  input state, lane A_in[x][y].
REQ-006 A_out  output  [0:4][0:4] x 64  permuted state, lane A_out[x][y].
REQ-007 busy  output  1  high while rounds are in progress.
REQ-008 done  output  1  single-cycle pulse when A_out holds a completed result.

Function
REQ-009 Lane convention: bit z of lane [x][y] is bit z of the 64-bit word, z = 0 is the LSB; x and y indices are taken mod 5.
REQ-010 Loading: a rising edge with start=1 and busy=0 shall set state := A_in, round counter := 0 and busy := 1.
REQ-011 start while busy=1 shall be ignored; it has no effect on state or the counter.
REQ-012 Each rising edge with busy=1 shall apply one round with RC[round], then increment the counter.
REQ-013 The round shall be theta, rho, pi, chi, iota in that order.
REQ-014 theta: C[x] = XOR over y of A[x][y]; D[x] = C[x-1] ^ rotl(C[x+1], 1); A[x][y] ^= D[x].
REQ-015 rho + pi: B[y][(2x+3y)%5] = rotl(A[x][y], r[x][y]).
REQ-016 r[x][y], x = 0..4 per row:
- y=0: 0, 1, 62, 28, 27
- y=1: 36, 44, 6, 55, 20
- y=2: 3, 10, 43, 25, 39
- y=3: 41, 45, 15, 21, 8
- y=4: 18, 2, 61, 56, 14
REQ-017 chi: A[x][y] = B[x][y] ^ (~B[x+1][y] & B[x+2][y]).
REQ-018 iota: A[0][0] ^= RC[i], where RC[0..23] are the FIPS 202 Keccak-f[1600] round constants (RC[0] = 0x0000000000000001, RC[23] = 0x8000000080008008).
REQ-019 On the edge that applies round NR-1, the block shall clear busy, set done=1 for exactly one cycle, and hold the counter.
REQ-020 Latency: the start edge is edge 0; the final round is applied on edge NR; done is high during the cycle following edge NR.
REQ-021 A_out shall be driven directly from the state register at all times; it is valid while done=1 and stays stable until the next accepted start.
REQ-022 start may be accepted in the same cycle that done=1 (back-to-back operation), since busy=0 in that cycle.
REQ-023 There is no output backpressure; a result not read before the next start is overwritten.

Reset
REQ-024 While rst_n=0, the block shall asynchronously force:
- all state lanes to 0, so A_out = 0
- round counter to 0
- busy = 0 and done = 0
REQ-025 Reset asserted mid-permutation shall abort the operation; no done pulse is produced for the aborted operation.
REQ-026 The first accepted start is the first rising edge with rst_n=1 and start=1.

Structure
REQ-027 A shared package keccak_pkg shall hold:
- the lane type (64 bits) and the state type (5x5 lanes)
- the RC[0:23] constant table
- the rho offset table r[x][y]
REQ-028 The combinational round shall be a sub-module keccak_round with ports A_in (state), rc (64 bits) and A_out (state).
REQ-029 keccak_round shall also expose theta_out (state after theta only) for unit verification.
REQ-030 The top level shall contain only the state register, the round counter, the busy/done control and one keccak_round instance; it shall not unroll rounds.

Verification
REQ-031 keccak_round theta check, all other lanes 0 on input:
- Input: A[0][0] = 0x1f, A[1][3] = 0x8000000000000000.
- For every y, theta_out[0..4][y] = 0x1e (y=0) or 0x01 (y=1..4), 0x1f, 0x8000000000000000, 0x0, 0x3e.
- Exception: theta_out[1][3] = 0x800000000000001f.
REQ-032 Zero-state permutation with NR=24:
- Apply all-zero A_in with start.
- done rises 24 edges after the start edge.
- A_out[0][0] = 0xF1258F7940E1DDE7 and A_out[1][0] = 0x84D5CCF933C0478A.
REQ-033 Pulse start during rounds 5 and 23 -> the result and done timing are identical to REQ-032, and no extra done pulse occurs.
REQ-034 Assert rst_n=0 at round 10 -> A_out = 0, busy = 0, done = 0 immediately without a clock edge; a following start yields the REQ-032 result.
REQ-035 Back-to-back: assert start in the done cycle with A_in = the previous A_out -> busy stays continuous, and a second done arrives 24 edges later.
REQ-036 Idle stability: with start=0 for 100 cycles after done, A_out is unchanged and busy = done = 0.
